// File: rtl/boot_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : boot_mem_arbiter
//  Purpose  : Shares the single byte-wide data-memory port between the WASM
//             boot loader (before boot_done) and the execution core (after
//             boot_done). Each access is a latched request/strobe/ack
//             handshake with a bounded wait; hung accesses abort with err.
//  Revision : 1.0  initial release
// ============================================================================
module boot_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_done,
    // loader requester
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_grant,
    output logic              ld_ack,
    // core requester
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              err,
    // memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    // Last counter value before the access is declared hung.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    owner_t     r_owner;
    logic [7:0] r_cnt;
    logic       r_we;

    // Phase selects which requester may even be considered in IDLE.
    logic w_ld_take;
    logic w_cpu_take;

    assign w_ld_take  = !boot_done && ld_req;
    assign w_cpu_take =  boot_done && cpu_req;

    // Loader bus enable: valid while IDLE could sample it and for its own access.
    assign ld_grant = ((r_state == S_IDLE) && !boot_done) ||
                      ((r_owner == OWN_LD) && (r_state != S_IDLE));

    // Access sequencer: accept, hold strobes until ready or timeout, then ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_NONE;
            r_cnt     <= 8'd0;
            r_we      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ld_ack  <= 1'b0;
                    cpu_ack <= 1'b0;
                    if (w_ld_take) begin
                        r_owner   <= OWN_LD;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                        mem_we    <= ld_we;
                        mem_re    <= !ld_we;
                        r_we      <= ld_we;
                        r_cnt     <= 8'd0;
                        err       <= 1'b0;
                        r_state   <= S_ACCESS;
                    end else if (w_cpu_take) begin
                        r_owner   <= OWN_CPU;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_we    <= cpu_we;
                        mem_re    <= !cpu_we;
                        r_we      <= cpu_we;
                        r_cnt     <= 8'd0;
                        err       <= 1'b0;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        // Only a successful core read updates the returned data.
                        if ((r_owner == OWN_CPU) && !r_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                        err     <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_re  <= 1'b0;
                        ld_ack  <= (r_owner == OWN_LD);
                        cpu_ack <= (r_owner == OWN_CPU);
                        r_state <= S_RESP;
                    end else if (r_cnt == C_TMO_LAST) begin
                        err     <= 1'b1;
                        mem_we  <= 1'b0;
                        mem_re  <= 1'b0;
                        ld_ack  <= (r_owner == OWN_LD);
                        cpu_ack <= (r_owner == OWN_CPU);
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    ld_ack  <= 1'b0;
                    cpu_ack <= 1'b0;
                    r_owner <= OWN_NONE;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_owner <= OWN_NONE;
                    mem_we  <= 1'b0;
                    mem_re  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_mem_arbiter
//  Purpose  : Self-checking bench for boot_mem_arbiter: directed scenarios
//             plus randomized accesses scored against a transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_boot_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_done;
    logic        ld_req, ld_we, ld_grant, ld_ack;
    logic [31:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        cpu_req, cpu_we, cpu_ack, err;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] model_rdata = 8'd0;

    boot_mem_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .boot_done(boot_done),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_grant(ld_grant), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One access from the eligible requester; memory answers on strobe
    // cycle delay+1. Called and returns at a falling edge with the DUT idle.
    task automatic run_access(input bit is_cpu, input bit we, input logic [31:0] addr,
                              input logic [7:0] wd, input logic [7:0] rd,
                              input int delay, input bit boot_mid, input string tag);
        int strobes = 0;
        int ack_at  = -1;
        bit bad_addr = 0, bad_dir = 0, bad_grant = 0, oth_ack = 0;
        logic got_err = 1'b0;
        int exp_strobes = (delay < TMO) ? delay + 1 : TMO;
        bit exp_err = (delay >= TMO);
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wd;
        end
        for (int c = 1; c <= TMO + 8 && ack_at < 0; c++) begin
            @(negedge clk);
            if (mem_we || mem_re) begin
                strobes++;
                if (mem_addr !== addr || (we && mem_wdata !== wd)) bad_addr = 1;
                if (mem_we !== we || mem_re !== !we) bad_dir = 1;
                if (ld_grant !== !is_cpu) bad_grant = 1;
                if (boot_mid && strobes == 1) begin
                    boot_done = 1'b1;
                    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; cpu_wdata = 8'h00;
                end
            end
            mem_ready = (mem_we || mem_re) && (strobes == delay + 1);
            mem_rdata = mem_ready ? rd : 8'($urandom);
            if (is_cpu ? ld_ack : cpu_ack) oth_ack = 1;
            if (is_cpu ? cpu_ack : ld_ack) begin
                ack_at  = c;
                got_err = err;
            end
        end
        mem_ready = 1'b0;
        if (is_cpu) cpu_req = 1'b0;
        else        ld_req  = 1'b0;
        if (is_cpu && !we && !exp_err) model_rdata = rd;
        chk({tag, ".ack_cycle"}, ack_at, exp_strobes + 1);
        chk({tag, ".strobes"}, strobes, exp_strobes);
        chk({tag, ".err"}, got_err, exp_err);
        chk({tag, ".addr_data"}, bad_addr, 0);
        chk({tag, ".strobe_dir"}, bad_dir, 0);
        chk({tag, ".grant"}, bad_grant, 0);
        chk({tag, ".other_ack"}, oth_ack, 0);
        if (is_cpu) chk({tag, ".rdata"}, cpu_rdata, model_rdata);
        @(negedge clk);
        chk({tag, ".idle_quiet"}, {mem_we, mem_re, ld_ack, cpu_ack}, 0);
    endtask

    initial begin
        int strobes;
        int acks;
        rst_n = 1'b0; boot_done = 1'b0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset.outputs", {mem_addr, mem_wdata, mem_we, mem_re, ld_ack, cpu_ack, cpu_rdata, err}, 0);
        chk("reset.ld_grant", ld_grant, 1);
        rst_n = 1'b1;

        // Loader write, one wait cycle.
        run_access(0, 1, 32'h30, 8'h41, 8'h00, 1, 0, "ld_wr");
        // Core read with immediate ready.
        boot_done = 1'b1;
        run_access(1, 0, 32'h34, 8'h00, 8'hA5, 0, 0, "cpu_rd");
        chk("cpu_rd.value", cpu_rdata, 8'hA5);

        // Core request ignored while the loader phase is active.
        boot_done = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h99;
        strobes = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we || mem_re) strobes++;
            if (cpu_ack) acks++;
        end
        chk("ineligible.strobes", strobes, 0);
        chk("ineligible.acks", acks, 0);
        chk("ineligible.grant", ld_grant, 1);
        boot_done = 1'b1;
        run_access(1, 0, 32'h99, 8'h00, 8'h3C, 0, 0, "late_boot");

        // Hung core write, then a clean access clears err.
        run_access(1, 1, 32'h40, 8'h77, 8'h00, 20, 0, "timeout");
        chk("timeout.rdata_kept", cpu_rdata, 8'h3C);
        run_access(1, 1, 32'h41, 8'h78, 8'h00, 0, 0, "after_to");

        // boot_done rises during a loader access while the core is requesting.
        boot_done = 1'b0;
        run_access(0, 1, 32'h60, 8'h5A, 8'h00, 2, 1, "ld_mid");
        run_access(1, 0, 32'h50, 8'h00, 8'hC3, 1, 0, "cpu_next");

        // Randomized mix of phases, directions, addresses and wait lengths.
        for (int i = 0; i < 40; i++) begin
            bit b = 1'($urandom_range(0, 1));
            bit noise = 1'($urandom_range(0, 1));
            boot_done = b;
            if (b) begin ld_req = noise; ld_we = 1'b1; ld_addr = $urandom; end
            else   begin cpu_req = noise; cpu_we = 1'b1; cpu_addr = $urandom; end
            run_access(b, 1'($urandom_range(0, 1)), $urandom, 8'($urandom), 8'($urandom),
                       int'($urandom_range(0, 6)), 0, $sformatf("rnd%0d", i));
        end
        ld_req = 1'b0; cpu_req = 1'b0;

        // Reset during an access drops it without an ack.
        boot_done = 1'b0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h77; ld_wdata = 8'h12; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid.pre_strobe", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.strobes", {mem_we, mem_re}, 0);
        ld_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ld_ack || cpu_ack) acks++;
        end
        chk("rst_mid.no_ack", acks, 0);
        chk("rst_mid.rdata", cpu_rdata, 0);
        model_rdata = 8'd0;
        rst_n = 1'b1;
        chk("rst_mid.grant", ld_grant, 1);
        run_access(0, 0, 32'h78, 8'h00, 8'h9E, 1, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
